// File: rtl/apb_mem_a_ctrl.sv
// apb_mem_a_ctrl
// APB slave giving the 32-bit register bus access to memory A, a WORDS x WIDTH
// single-port memory with one cycle of read latency. Each memory word is split
// into two 32-bit APB slots: half 0 at byte offset idx*8 and half 1 at
// idx*8+4. The low half of a write is staged and written to memory with the
// high half. A read fills a hold register so that the following read of the
// high half completes without a memory access. After reset the controller
// zero-fills the memory before it accepts any APB access.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   psel, penable, pwrite     APB control
//   paddr, pwdata             APB byte address (block-local) and write data
//   pready, prdata, pslverr   APB response (combinational)
//   mem_rd_en, mem_wr_en      memory strobes (combinational, never both high)
//   mem_addr, mem_wdata       memory word address and write data
//   mem_rdata                 memory read data, valid the cycle after mem_rd_en
module apb_mem_a_ctrl #(
  parameter int WORDS = 19,
  parameter int WIDTH = 63,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             psel,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [31:0]      paddr,
  input  logic [31:0]      pwdata,
  output logic             pready,
  output logic [31:0]      prdata,
  output logic             pslverr,
  output logic             mem_rd_en,
  output logic             mem_wr_en,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    IDLE    = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic [AW-1:0]    initCnt;
  logic [AW-1:0]    initCntNext;
  logic [31:0]      stageLo;
  logic             stageLoWe;
  logic [WIDTH-1:0] hold;
  logic [AW-1:0]    holdIdx;
  logic             holdVld;
  logic             holdSet;
  logic             holdClr;
  logic [AW-1:0]    rdIdx;
  logic             rdHalf;
  logic             rdIssue;

  logic [4:0]       idx;
  logic [AW-1:0]    idxAw;
  logic             half;
  logic             access;
  logic             addrErr;
  logic             holdHit;
  logic             unusedBits;

  // Upper slot of a memory word, zero-extended to the 32-bit bus.
  function automatic logic [31:0] upperHalf(input logic [WIDTH-1:0] w);
    return 32'(w >> 32);
  endfunction

  function automatic logic [31:0] selHalf(input logic [WIDTH-1:0] w, input logic h);
    return h ? upperHalf(w) : w[31:0];
  endfunction

  // High pwdata bits beyond WIDTH-33 do not fit in the word and are dropped.
  function automatic logic [WIDTH-1:0] packWord(input logic [31:0] hi, input logic [31:0] lo);
    return WIDTH'({hi, lo});
  endfunction

  assign idx        = paddr[7:3];
  assign idxAw      = AW'(idx);
  assign half       = paddr[2];
  assign access     = psel & penable;
  assign addrErr    = (paddr[31:8] != 24'd0) || (32'(idx) >= 32'(WORDS));
  assign holdHit    = holdVld && (holdIdx == idxAw);
  assign unusedBits = ^paddr[1:0];

  always_comb begin
    stateNext   = state;
    initCntNext = initCnt;
    pready      = 1'b0;
    prdata      = '0;
    pslverr     = 1'b0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    stageLoWe   = 1'b0;
    holdSet     = 1'b0;
    holdClr     = 1'b0;
    rdIssue     = 1'b0;
    // Outputs stay at their reset values while rst is held.
    if (!rst) begin
      unique case (state)
        INIT: begin
          mem_wr_en   = 1'b1;
          mem_addr    = initCnt;
          initCntNext = initCnt + AW'(1);
          if (initCnt == AW'(WORDS - 1)) begin
            stateNext   = IDLE;
            initCntNext = '0;
          end
        end
        IDLE: begin
          if (access) begin
            if (addrErr) begin
              pready  = 1'b1;
              pslverr = 1'b1;
            end else if (pwrite) begin
              pready = 1'b1;
              if (!half) begin
                stageLoWe = 1'b1;
              end else begin
                mem_wr_en = 1'b1;
                mem_addr  = idxAw;
                mem_wdata = packWord(pwdata, stageLo);
                holdClr   = holdHit;
              end
            end else if (half && holdHit) begin
              pready = 1'b1;
              prdata = upperHalf(hold);
            end else begin
              mem_rd_en = 1'b1;
              mem_addr  = idxAw;
              rdIssue   = 1'b1;
              stateNext = RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          pready    = 1'b1;
          prdata    = selHalf(mem_rdata, rdHalf);
          holdSet   = 1'b1;
          stateNext = IDLE;
        end
        default: stateNext = INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      initCnt <= '0;
      stageLo <= '0;
      holdVld <= 1'b0;
    end else begin
      state   <= stateNext;
      initCnt <= initCntNext;
      if (stageLoWe) begin
        stageLo <= pwdata;
      end
      if (holdSet) begin
        holdVld <= 1'b1;
      end else if (holdClr) begin
        holdVld <= 1'b0;
      end
    end
  end

  // Read address/half captured at issue; hold loaded when the data returns.
  always_ff @(posedge clk) begin
    if (rdIssue) begin
      rdIdx  <= idxAw;
      rdHalf <= half;
    end
    if (holdSet) begin
      hold    <= mem_rdata;
      holdIdx <= rdIdx;
    end
  end

endmodule

// File: tb/tb_apb_mem_a_ctrl.sv
module tb_apb_mem_a_ctrl;

  localparam int WORDS = 19;
  localparam int WIDTH = 63;
  localparam int AW    = 5;
  localparam logic [63:0] MASK = (64'd1 << WIDTH) - 64'd1;

  logic             clk = 1'b0;
  logic             rst;
  logic             psel;
  logic             penable;
  logic             pwrite;
  logic [31:0]      paddr;
  logic [31:0]      pwdata;
  logic             pready;
  logic [31:0]      prdata;
  logic             pslverr;
  logic             mem_rd_en;
  logic             mem_wr_en;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  apb_mem_a_ctrl #(.WORDS(WORDS), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready), .prdata(prdata),
    .pslverr(pslverr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory A: one cycle read latency.
  logic [WIDTH-1:0] mem [0:31];
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  int errors = 0;
  int checks = 0;

  // Strobe log, filled at negedges by the stimulus process.
  int               logWr;
  int               logRd;
  int               bothTotal = 0;
  logic [AW-1:0]    lastRdAddr;
  logic [AW-1:0]    wrAddrQ[$];
  logic [WIDTH-1:0] wrDataQ[$];

  // Transfer results.
  int          xWaits;
  logic [31:0] xRdata;
  logic        xErr;

  // Reference model: memory contents, staged low half, hold tag.
  logic [63:0] refMem [0:31];
  logic [31:0] refStage;
  bit          refHv;
  int          refHi;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clearLog();
    logWr = 0;
    logRd = 0;
    lastRdAddr = '0;
    wrAddrQ.delete();
    wrDataQ.delete();
  endtask

  task automatic sampleStrobes();
    if (mem_wr_en) begin
      logWr++;
      wrAddrQ.push_back(mem_addr);
      wrDataQ.push_back(mem_wdata);
    end
    if (mem_rd_en) begin
      logRd++;
      lastRdAddr = mem_addr;
    end
    if (mem_wr_en && mem_rd_en) bothTotal++;
  endtask

  task automatic resetModel();
    for (int i = 0; i < 32; i++) refMem[i] = 64'd0;
    refStage = 32'd0;
    refHv = 1'b0;
    refHi = 0;
  endtask

  // Called just after a posedge; returns just after the posedge following completion.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data, input bit clr);
    bit done;
    if (clr) clearLog();
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(negedge clk); sampleStrobes();
    @(posedge clk); #1 penable = 1'b1;
    xWaits = 0; done = 1'b0; xRdata = '0; xErr = 1'b0;
    while (!done) begin
      @(negedge clk); sampleStrobes();
      if (pready) begin
        done = 1'b1; xRdata = prdata; xErr = pslverr;
      end else begin
        xWaits++;
        if (xWaits > 40) begin
          checks++; errors++;
          $error("FAIL timeout addr=%0h got=no_pready exp=pready", addr);
          done = 1'b1;
        end else begin
          @(posedge clk); #1;
        end
      end
    end
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // One transfer checked against the reference model.
  task automatic mxfer(input string step, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    int          idx;
    bit          half;
    bit          err;
    int          eWait;
    int          eWr;
    int          eRd;
    logic [31:0] eData;
    logic [63:0] eWord;
    idx = int'(addr[7:3]);
    half = addr[2];
    err = (addr[31:8] != 24'd0) || (idx >= WORDS);
    eWait = 0; eWr = 0; eRd = 0; eData = 32'd0; eWord = 64'd0;
    if (err) begin
      eData = 32'd0;
    end else if (wr) begin
      if (!half) begin
        refStage = data;
      end else begin
        eWr = 1;
        eWord = {data, refStage} & MASK;
        refMem[idx] = eWord;
        if (refHv && refHi == idx) refHv = 1'b0;
      end
    end else if (half && refHv && refHi == idx) begin
      eData = refMem[idx][63:32];
    end else begin
      eWait = 1; eRd = 1;
      eData = half ? refMem[idx][63:32] : refMem[idx][31:0];
      refHv = 1'b1; refHi = idx;
    end
    xfer(wr, addr, data, 1'b1);
    chk({step, ".wait"}, 64'(xWaits), 64'(eWait));
    chk({step, ".slverr"}, 64'(xErr), 64'(err));
    if (!wr || err) chk({step, ".rdata"}, 64'(xRdata), 64'(eData));
    chk({step, ".wrN"}, 64'(logWr), 64'(eWr));
    chk({step, ".rdN"}, 64'(logRd), 64'(eRd));
    if (eWr == 1 && wrAddrQ.size() == 1) begin
      chk({step, ".wrAddr"}, 64'(wrAddrQ[0]), 64'(idx));
      chk({step, ".wrData"}, 64'(wrDataQ[0]), eWord);
    end
    if (eRd == 1) chk({step, ".rdAddr"}, 64'(lastRdAddr), 64'(idx));
  endtask

  // Checks a captured init sweep: WORDS zero writes to addresses 0..WORDS-1.
  task automatic chkInitSweep(input string step);
    bit dataZero;
    chk({step, ".initWrN"}, 64'(logWr), 64'(WORDS));
    for (int i = 0; i < WORDS; i++) begin
      chk($sformatf("%s.initAddr%0d", step, i),
          (i < wrAddrQ.size()) ? 64'(wrAddrQ[i]) : 64'hFF, 64'(i));
    end
    dataZero = 1'b1;
    foreach (wrDataQ[i]) if (wrDataQ[i] != '0) dataZero = 1'b0;
    chk({step, ".initDataZero"}, 64'(dataZero), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        wr;
    int          idx;
    logic [31:0] addr;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    resetModel();
    clearLog();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.pready", 64'(pready), 64'd0);
    chk("rst.prdata", 64'(prdata), 64'd0);
    chk("rst.pslverr", 64'(pslverr), 64'd0);
    chk("rst.mem_rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst.mem_wr_en", 64'(mem_wr_en), 64'd0);
    chk("rst.mem_addr", 64'(mem_addr), 64'd0);
    chk("rst.mem_wdata", 64'(mem_wdata), 64'd0);

    // Read issued during INIT: stalls to the first IDLE cycle, then one wait state.
    @(posedge clk); #1 rst = 1'b0;
    clearLog();
    @(negedge clk); sampleStrobes();
    @(posedge clk); #1;
    xfer(1'b0, 32'h00, 32'd0, 1'b0);
    chk("initRd.wait", 64'(xWaits), 64'd18);
    chk("initRd.rdata", 64'(xRdata), 64'd0);
    chk("initRd.slverr", 64'(xErr), 64'd0);
    chk("initRd.rdN", 64'(logRd), 64'd1);
    chkInitSweep("init");
    refHv = 1'b1; refHi = 0;

    // Split write of word 5.
    mxfer("wrLo5", 1'b1, 32'h28, 32'h89ABCDEF);
    mxfer("wrHi5", 1'b1, 32'h2C, 32'h12345678);
    chk("wrHi5.literal", (wrDataQ.size() > 0) ? 64'(wrDataQ[0]) : 64'd0,
        64'h12345678_89ABCDEF & MASK);

    // Miss then hold hit.
    mxfer("rdLo5", 1'b0, 32'h28, 32'd0);
    chk("rdLo5.literal", 64'(xRdata), 64'h89ABCDEF);
    mxfer("rdHi5hit", 1'b0, 32'h2C, 32'd0);
    chk("rdHi5hit.literal", 64'(xRdata), 64'h12345678);

    // Address errors leave the staged low half alone.
    mxfer("errIdx19", 1'b0, 32'h9C, 32'd0);
    mxfer("errHiAddr", 1'b1, 32'h100, 32'h55555555);
    mxfer("wrHi2", 1'b1, 32'h14, 32'hAAAA5555);
    chk("wrHi2.stageKept", (wrDataQ.size() > 0) ? 64'(wrDataQ[0][31:0]) : 64'd0, 64'h89ABCDEF);

    // Write of half 1 invalidates the hold for that word.
    mxfer("rdLo5b", 1'b0, 32'h28, 32'd0);
    mxfer("wrHi5b", 1'b1, 32'h2C, 32'h0BADF00D);
    mxfer("rdHi5miss", 1'b0, 32'h2C, 32'd0);
    chk("rdHi5miss.literal", 64'(xRdata), 64'h0BADF00D);

    // Top pwdata bit does not fit in a 63-bit word.
    mxfer("wrHiFull", 1'b1, 32'h4C, 32'hFFFFFFFF);
    mxfer("rdHiFull", 1'b0, 32'h4C, 32'd0);
    mxfer("rdHiFullHit", 1'b0, 32'h4C, 32'd0);
    chk("rdHiFullHit.literal", 64'(xRdata), 64'h7FFFFFFF);

    // Randomized traffic, biased towards a few words to exercise the hold.
    for (int n = 0; n < 80; n++) begin
      wr = 1'($urandom_range(0, 1));
      idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(4, 7));
      addr = {24'd0, 5'(idx), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 15) == 0) addr[31:8] = 24'($urandom_range(1, 24'hFFFFFF));
      mxfer($sformatf("rnd%0d", n), wr, addr, $urandom);
    end

    // Reset while a read is in RD_WAIT.
    mxfer("preRst", 1'b0, 32'h28, 32'd0);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h30;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    chk("rstRdWait.issue", 64'(mem_rd_en), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rstRdWait.pready", 64'(pready), 64'd0);
    @(posedge clk); #1 rst = 1'b0; psel = 1'b0; penable = 1'b0;
    clearLog();
    resetModel();
    @(negedge clk); sampleStrobes();
    chk("reinit.pready", 64'(pready), 64'd0);
    chk("reinit.firstAddr", 64'(mem_addr), 64'd0);
    chk("reinit.firstWr", 64'(mem_wr_en), 64'd1);
    repeat (WORDS - 1) begin
      @(negedge clk); sampleStrobes();
    end
    chkInitSweep("reinit");
    @(posedge clk); #1;
    mxfer("postRstHi5", 1'b0, 32'h2C, 32'd0);
    mxfer("postRstLo5", 1'b0, 32'h28, 32'd0);

    chk("noOverlap", 64'(bothTotal), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
